// File: rtl/fp_minmax_tracker_pkg.sv
// Shared constants, state encodings and float helpers for the min/max tracker.
package fp_minmax_tracker_pkg;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == FP_EXP_MAX) && (f[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_minmax_tracker_compare.sv
// Combinational single-precision ordering a >= b (sign, exponent, mantissa; +0 > -0).
// Operands are expected to be non-NaN; raw bit patterns are compared, so denormals are not flushed.
module fp_minmax_tracker_compare (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        a_ge_b_o
);

    logic mag_ge;
    logic mag_le;

    assign mag_ge = (a_i[30:0] >= b_i[30:0]);
    assign mag_le = (a_i[30:0] <= b_i[30:0]);

    // Differing signs: the positive operand wins, which also ranks +0 above -0.
    always_comb begin
        if (a_i[31] != b_i[31]) begin
            a_ge_b_o = ~a_i[31];
        end else if (a_i[31]) begin
            a_ge_b_o = mag_le;
        end else begin
            a_ge_b_o = mag_ge;
        end
    end

endmodule

// File: rtl/fp_minmax_tracker.sv
// Streaming float min/max tracker: accumulates a framed valid/ready stream and
// presents one registered result per frame until the consumer accepts it.
module fp_minmax_tracker
    import fp_minmax_tracker_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_min,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_nan,
    output logic             out_empty,
    output logic             out_ovf
);

    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [1:0]       state_q,   state_d;
    logic [31:0]      min_q,     min_d;
    logic [31:0]      max_q,     max_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W:0]   count_q,   count_d;
    logic             nan_q,     nan_d;
    logic             have_q,    have_d;
    logic             empty_q,   empty_d;
    logic             ovf_q,     ovf_d;

    logic             accept;
    logic             x_nan;
    logic             max_ge_x;
    logic             x_ge_min;
    logic [IDX_W-1:0] beat_idx;

    assign in_ready = (state_q != ST_DONE);
    assign accept   = in_valid && in_ready;
    assign x_nan    = is_nan(in_data);

    // Once the count has saturated, any further updating beat reports an all-ones index.
    assign beat_idx = count_q[IDX_W] ? {IDX_W{1'b1}} : count_q[IDX_W-1:0];

    fp_minmax_tracker_compare u_max_cmp (
        .a_i      (max_q),
        .b_i      (in_data),
        .a_ge_b_o (max_ge_x)
    );

    fp_minmax_tracker_compare u_min_cmp (
        .a_i      (in_data),
        .b_i      (min_q),
        .a_ge_b_o (x_ge_min)
    );

    // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;
        nan_d     = nan_q;
        have_d    = have_q;
        empty_d   = empty_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    if (count_q[IDX_W]) ovf_d = 1'b1;
                    else                count_d = count_q + CNT_ONE;

                    if (x_nan) begin
                        nan_d = 1'b1;
                    end else if (!have_q) begin
                        min_d     = in_data;
                        max_d     = in_data;
                        min_idx_d = beat_idx;
                        max_idx_d = beat_idx;
                    end else begin
                        // Strict improvement only, so ties keep the earlier index.
                        if (!max_ge_x) begin
                            max_d     = in_data;
                            max_idx_d = beat_idx;
                        end
                        if (!x_ge_min) begin
                            min_d     = in_data;
                            min_idx_d = beat_idx;
                        end
                    end
                    have_d = have_q || !x_nan;

                    if (in_last) begin
                        state_d = ST_DONE;
                        empty_d = !have_d;
                        if (!have_d) begin
                            min_d     = FP_QNAN;
                            max_d     = FP_QNAN;
                            min_idx_d = '0;
                            max_idx_d = '0;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    min_d     = '0;
                    max_d     = '0;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    count_d   = '0;
                    nan_d     = 1'b0;
                    have_d    = 1'b0;
                    empty_d   = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            nan_q     <= 1'b0;
            have_q    <= 1'b0;
            empty_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            nan_q     <= nan_d;
            have_q    <= have_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid   = (state_q == ST_DONE);
    assign out_min     = min_q;
    assign out_max     = max_q;
    assign out_min_idx = min_idx_q;
    assign out_max_idx = max_idx_q;
    assign out_count   = count_q;
    assign out_nan     = nan_q;
    assign out_empty   = empty_q;
    assign out_ovf     = ovf_q;

endmodule
